// File: rtl/int_to_float_pipe_if.sv
// Sample/result handshake bundle for int_to_float_pipe.
// The converter uses the slave view; the producer/consumer side uses the master view.
interface int_to_float_pipe_if #(
  parameter int IN_W = 16
) ();
  logic            in_valid;
  logic            in_ready;
  logic [IN_W-1:0] in_data;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_data;
  logic            out_inexact;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_inexact
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_inexact
  );
endinterface

// File: rtl/int_to_float_pipe.sv
// Three-stage elastic fixed-point to IEEE-754 single converter (sign/abs, normalise, pack).
// Define ROUND_NEAREST_EVEN_EN for round-to-nearest-even; otherwise wide inputs are truncated.
module int_to_float_pipe #(
  parameter int IN_W        = 16,
  parameter int FRAC_W      = 0,
  parameter int SIGNED_MODE = 0
) (
  input logic               clk,
  input logic               reset,
  input logic               enable,
  int_to_float_pipe_if.slave bus
);

  localparam int PW    = (IN_W > 2) ? $clog2(IN_W) : 1;
  localparam int EXT_W = IN_W + 23;

  function automatic logic [IN_W:0] sign_abs(input logic [IN_W-1:0] raw);
    logic signed [IN_W-1:0] v;
    logic [IN_W-1:0]        mag;
    v = raw;
    // Negation at full width keeps -2^(IN_W-1) exact as an unsigned magnitude.
    if (SIGNED_MODE != 0) mag = (v < 0) ? unsigned'(-v) : unsigned'(v);
    else                  mag = {1'b0, raw[IN_W-2:0]};
    return {raw[IN_W-1], mag};
  endfunction

  function automatic logic [PW-1:0] lead_one(input logic [IN_W-1:0] m);
    logic [PW-1:0] pos;
    pos = '0;
    for (int i = 0; i < IN_W; i++) begin
      if (m[i]) pos = PW'(i);
    end
    return pos;
  endfunction

`ifdef ROUND_NEAREST_EVEN_EN
  function automatic logic [30:0] round_rne(input logic [7:0] e, input logic [22:0] m,
                                            input logic [IN_W-1:0] rem);
    logic g;
    logic s;
    g = rem[IN_W-1];
    s = |rem[IN_W-2:0];
    // A carry out of the mantissa ripples into the exponent field.
    if (g && (s || m[0])) return {e, m} + 31'd1;
    return {e, m};
  endfunction
`endif

  logic            vld_p0_q, vld_p1_q, vld_p2_q;
  logic            vld_p0_d, vld_p1_d, vld_p2_d;
  logic            sign_p0_q;
  logic [IN_W-1:0] mag_p0_q;
  logic            sign_p1_q, zero_p1_q;
  logic [PW-1:0]   pos_p1_q;
  logic [IN_W-1:0] norm_p1_q;
  logic [31:0]     data_p2_q, data_p2_d;
  logic            inexact_p2_q, inexact_p2_d;

  logic            out_valid_w, vacate_p2, mv_p1, mv_p0, in_ready_w, accept;
  logic [IN_W:0]   sa_w;
  logic [PW-1:0]   pos_p1_d;
  logic [PW-1:0]   shift_w;
  logic [IN_W-1:0] norm_p1_d;
  logic [EXT_W-1:0] ext_w;
  logic [22:0]     mant_w;
  logic [IN_W-1:0] rem_w;
  logic [7:0]      exp_w;
  logic [30:0]     packed_w;

  assign out_valid_w = vld_p2_q & enable;
  assign vacate_p2   = out_valid_w & bus.out_ready;
  assign mv_p1       = enable & vld_p1_q & (~vld_p2_q | vacate_p2);
  assign mv_p0       = enable & vld_p0_q & (~vld_p1_q | mv_p1);
  assign in_ready_w  = ~reset & enable & (~vld_p0_q | mv_p0);
  assign accept      = bus.in_valid & in_ready_w;

  always_comb begin
    vld_p0_d = vld_p0_q;
    vld_p1_d = vld_p1_q;
    vld_p2_d = vld_p2_q;
    if (accept)         vld_p0_d = 1'b1;
    else if (mv_p0)     vld_p0_d = 1'b0;
    if (mv_p0)          vld_p1_d = 1'b1;
    else if (mv_p1)     vld_p1_d = 1'b0;
    if (mv_p1)          vld_p2_d = 1'b1;
    else if (vacate_p2) vld_p2_d = 1'b0;
  end

  // S1: sign and magnitude
  assign sa_w = sign_abs(bus.in_data);

  // S2: leading-one detect, left-normalise to bit IN_W-1
  assign pos_p1_d  = lead_one(mag_p0_q);
  assign shift_w   = PW'(IN_W - 1) - pos_p1_d;
  assign norm_p1_d = mag_p0_q << shift_w;

  // S3: exponent, mantissa pack, optional rounding
  always_comb begin
    ext_w  = {norm_p1_q[IN_W-2:0], 24'd0};
    mant_w = ext_w[EXT_W-1 -: 23];
    rem_w  = ext_w[IN_W-1:0];
    exp_w  = 8'd127 + 8'(pos_p1_q) - 8'(FRAC_W);
`ifdef ROUND_NEAREST_EVEN_EN
    packed_w = round_rne(exp_w, mant_w, rem_w);
`else
    packed_w = {exp_w, mant_w};
`endif
    data_p2_d    = {sign_p1_q, packed_w};
    inexact_p2_d = |rem_w;
    if (zero_p1_q) begin
      data_p2_d    = {sign_p1_q, 31'd0};
      inexact_p2_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p0_q     <= 1'b0;
      vld_p1_q     <= 1'b0;
      vld_p2_q     <= 1'b0;
      data_p2_q    <= 32'h0;
      inexact_p2_q <= 1'b0;
    end else begin
      vld_p0_q <= vld_p0_d;
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
      if (mv_p1) begin
        data_p2_q    <= data_p2_d;
        inexact_p2_q <= inexact_p2_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      sign_p0_q <= sa_w[IN_W];
      mag_p0_q  <= sa_w[IN_W-1:0];
    end
    if (mv_p0) begin
      sign_p1_q <= sign_p0_q;
      zero_p1_q <= (mag_p0_q == '0);
      pos_p1_q  <= pos_p1_d;
      norm_p1_q <= norm_p1_d;
    end
  end

  assign bus.in_ready    = in_ready_w;
  assign bus.out_valid   = out_valid_w;
  assign bus.out_data    = data_p2_q;
  assign bus.out_inexact = inexact_p2_q;

endmodule

// File: tb/tb_int_to_float_pipe.sv
// Bench for int_to_float_pipe: six parameterisations share one stimulus stream and are
// scored against a floating-point reference model built on $realtobits.
module tb_int_to_float_pipe;

  localparam int NI = 6;
  localparam int PIW [NI] = '{16, 16, 16, 32, 32, 4};
  localparam int PFR [NI] = '{ 0,  0,  8,  0,  5, 3};
  localparam int PSM [NI] = '{ 0,  1,  0,  0,  1, 1};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] din = 32'h0;

  always #5 clk = ~clk;

  int_to_float_pipe_if #(.IN_W(16)) if0 ();
  int_to_float_pipe_if #(.IN_W(16)) if1 ();
  int_to_float_pipe_if #(.IN_W(16)) if2 ();
  int_to_float_pipe_if #(.IN_W(32)) if3 ();
  int_to_float_pipe_if #(.IN_W(32)) if4 ();
  int_to_float_pipe_if #(.IN_W(4))  if5 ();

  int_to_float_pipe #(.IN_W(16), .FRAC_W(0), .SIGNED_MODE(0)) u0 (.clk(clk), .reset(reset), .enable(enable), .bus(if0));
  int_to_float_pipe #(.IN_W(16), .FRAC_W(0), .SIGNED_MODE(1)) u1 (.clk(clk), .reset(reset), .enable(enable), .bus(if1));
  int_to_float_pipe #(.IN_W(16), .FRAC_W(8), .SIGNED_MODE(0)) u2 (.clk(clk), .reset(reset), .enable(enable), .bus(if2));
  int_to_float_pipe #(.IN_W(32), .FRAC_W(0), .SIGNED_MODE(0)) u3 (.clk(clk), .reset(reset), .enable(enable), .bus(if3));
  int_to_float_pipe #(.IN_W(32), .FRAC_W(5), .SIGNED_MODE(1)) u4 (.clk(clk), .reset(reset), .enable(enable), .bus(if4));
  int_to_float_pipe #(.IN_W(4),  .FRAC_W(3), .SIGNED_MODE(1)) u5 (.clk(clk), .reset(reset), .enable(enable), .bus(if5));

  assign if0.in_data = din[15:0];
  assign if1.in_data = din[15:0];
  assign if2.in_data = din[15:0];
  assign if3.in_data = din;
  assign if4.in_data = din;
  assign if5.in_data = din[3:0];
  assign {if0.in_valid, if1.in_valid, if2.in_valid, if3.in_valid, if4.in_valid, if5.in_valid} = {6{in_valid}};
  assign {if0.out_ready, if1.out_ready, if2.out_ready, if3.out_ready, if4.out_ready, if5.out_ready} = {6{out_ready}};

  logic [31:0] od [NI];
  logic        oi [NI];
  logic        ov [NI];
  logic        ir [NI];
  assign {od[0], oi[0], ov[0], ir[0]} = {if0.out_data, if0.out_inexact, if0.out_valid, if0.in_ready};
  assign {od[1], oi[1], ov[1], ir[1]} = {if1.out_data, if1.out_inexact, if1.out_valid, if1.in_ready};
  assign {od[2], oi[2], ov[2], ir[2]} = {if2.out_data, if2.out_inexact, if2.out_valid, if2.in_ready};
  assign {od[3], oi[3], ov[3], ir[3]} = {if3.out_data, if3.out_inexact, if3.out_valid, if3.in_ready};
  assign {od[4], oi[4], ov[4], ir[4]} = {if4.out_data, if4.out_inexact, if4.out_valid, if4.in_ready};
  assign {od[5], oi[5], ov[5], ir[5]} = {if5.out_data, if5.out_inexact, if5.out_valid, if5.in_ready};

  logic [32:0] exq  [NI][$];
  logic [33:0] ovr  [NI];
  logic        held [NI];
  logic [32:0] hval [NI];
  logic        acc;
  int          nvec = 0;
  int          nmis = 0;

  // Reference: value = magnitude * 2^-FRAC_W, taken from its double encoding.
  function automatic logic [32:0] model(input logic [31:0] raw, input int k);
    int          w;
    logic [31:0] x;
    logic        sgn;
    longint      v, mag;
    real         r;
    logic [63:0] b;
    logic [7:0]  e;
    logic [22:0] m;
    logic [28:0] rem;
    w = PIW[k];
    x = (w == 32) ? raw : (raw & ((32'd1 << w) - 32'd1));
    sgn = x[w-1];
    if (PSM[k] == 0) begin
      mag = longint'(x) & ((64'sd1 <<< (w - 1)) - 64'sd1);
    end else begin
      v   = sgn ? (longint'(x) - (64'sd1 <<< w)) : longint'(x);
      mag = (v < 0) ? -v : v;
    end
    if (mag == 0) return {1'b0, sgn, 31'd0};
    r = real'(mag);
    for (int i = 0; i < PFR[k]; i++) r = r / 2.0;
    b   = $realtobits(r);
    e   = 8'(int'(b[62:52]) - 1023 + 127);
    m   = b[51:29];
    rem = b[28:0];
`ifdef ROUND_NEAREST_EVEN_EN
    if (rem[28] && ((rem[27:0] != 0) || m[0])) {e, m} = {e, m} + 31'd1;
`endif
    return {(rem != 0), sgn, e, m};
  endfunction

  function automatic logic [33:0] fx(input logic [31:0] d, input logic inx);
    return {1'b1, inx, d};
  endfunction

  task automatic chk(input string tag, input int k, input logic [63:0] obs, input logic [63:0] req);
    nvec++;
    assert (obs === req) else begin
      nmis++;
      $error("FAIL %s inst=%0d observed=%0h expected=%0h", tag, k, obs, req);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    acc = in_valid && ir[0];
    for (int k = 0; k < NI; k++) begin
      if (held[k]) begin
        chk("hold_valid", k, 64'(ov[k]), 64'd1);
        chk("hold_data", k, 64'({oi[k], od[k]}), 64'(hval[k]));
      end
      if (exq[k].size() == 0) chk("no_spurious", k, 64'(ov[k]), 64'd0);
      else if (ov[k] && out_ready) chk("result", k, 64'({oi[k], od[k]}), 64'(exq[k].pop_front()));
      held[k] = ov[k] && !out_ready;
      hval[k] = {oi[k], od[k]};
      if (in_valid && ir[k]) exq[k].push_back(ovr[k][33] ? ovr[k][32:0] : model(din, k));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] raw, output int waits);
    din = raw;
    in_valid = 1'b1;
    waits = 0;
    cycle();
    while (!acc && waits < 40) begin
      cycle();
      waits++;
    end
    chk("accept", 0, 64'(acc), 64'd1);
    for (int k = 0; k < NI; k++) ovr[k] = '0;
  endtask

  task automatic drain(input int n);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (n) cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, lat, n, t;
    logic [31:0] bp [6];
    for (int k = 0; k < NI; k++) begin
      ovr[k]  = '0;
      held[k] = 1'b0;
      hval[k] = '0;
    end

    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      chk("rst_in_ready", k, 64'(ir[k]), 64'd0);
      chk("rst_out_valid", k, 64'(ov[k]), 64'd0);
      chk("rst_out_data", k, 64'(od[k]), 64'd0);
      chk("rst_inexact", k, 64'(oi[k]), 64'd0);
    end
    reset = 1'b0;

    // Directed vectors, back to back.
    ovr[0] = fx(32'h46800000, 1'b0);                                   send(32'h00004000, w); chk("tput", 0, 64'(w), 64'd0);
    ovr[0] = fx(32'h3F800000, 1'b0); ovr[2] = fx(32'h3B800000, 1'b0); send(32'h00000001, w); chk("tput", 0, 64'(w), 64'd0);
    ovr[0] = fx(32'hC0400000, 1'b0);                                   send(32'h00008003, w); chk("tput", 0, 64'(w), 64'd0);
    ovr[0] = fx(32'h00000000, 1'b0);                                   send(32'h00000000, w); chk("tput", 0, 64'(w), 64'd0);
    ovr[0] = fx(32'h80000000, 1'b0); ovr[1] = fx(32'hC7000000, 1'b0); send(32'h00008000, w); chk("tput", 0, 64'(w), 64'd0);
    ovr[1] = fx(32'hBF800000, 1'b0);                                   send(32'h0000FFFF, w); chk("tput", 0, 64'(w), 64'd0);
    ovr[2] = fx(32'h3FC00000, 1'b0);                                   send(32'h00000180, w); chk("tput", 0, 64'(w), 64'd0);
`ifdef ROUND_NEAREST_EVEN_EN
    ovr[3] = fx(32'h4B800002, 1'b1); send(32'h01000003, w);
    ovr[3] = fx(32'h4C000000, 1'b1); send(32'h01FFFFFF, w);
`else
    ovr[3] = fx(32'h4B800001, 1'b1); send(32'h01000003, w);
    ovr[3] = fx(32'h4BFFFFFF, 1'b1); send(32'h01FFFFFF, w);
`endif
    send(32'h80000000, w);
    send(32'h7FFFFFFF, w);
    drain(6);

    // Latency from handshake to out_valid on an empty pipeline.
    ovr[0] = fx(32'h3F800000, 1'b0);
    send(32'h00000001, w);
    in_valid = 1'b0;
    lat = 1;
    while (!ov[0] && lat < 10) begin
      cycle();
      lat++;
    end
    chk("latency", 0, 64'(lat), 64'd3);
    drain(4);

    // Backpressure: six samples, five stalled cycles.
    for (int i = 0; i < 6; i++) bp[i] = 32'h00000101 * (i + 3);
    out_ready = 1'b0;
    in_valid = 1'b1;
    n = 0;
    t = 0;
    while (n < 6 && t < 40) begin
      if (t == 5) begin
        chk("bp_accepts", 0, 64'(n), 64'd3);
        for (int k = 0; k < NI; k++) begin
          chk("bp_in_ready", k, 64'(ir[k]), 64'd0);
          chk("bp_out_valid", k, 64'(ov[k]), 64'd1);
        end
        out_ready = 1'b1;
      end
      din = bp[n];
      cycle();
      if (acc) n++;
      t++;
    end
    chk("bp_all_in", 0, 64'(n), 64'd6);
    drain(6);

    // Global enable low holds the pipe and refuses input.
    send(32'h00001234, w);
    send(32'h0000F00D, w);
    din = 32'h00000055;
    enable = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) chk("en_in_ready", k, 64'(ir[k]), 64'd0);
    repeat (3) cycle();
    enable = 1'b1;
    drain(6);

    // Reset with three samples in flight.
    send(32'h00000011, w);
    send(32'h00000022, w);
    send(32'h00000033, w);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    for (int k = 0; k < NI; k++) begin
      chk("mid_rst_valid", k, 64'(ov[k]), 64'd0);
      chk("mid_rst_data", k, 64'(od[k]), 64'd0);
      chk("mid_rst_ready", k, 64'(ir[k]), 64'd0);
      exq[k].delete();
      held[k] = 1'b0;
    end
    @(posedge clk);
    #1 reset = 1'b0;
    drain(5);
    ovr[0] = fx(32'h46800000, 1'b0);
    send(32'h00004000, w);
    drain(6);

    // Randomised traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(9) < 7);
      out_ready = ($urandom_range(9) < 7);
      din       = $urandom >> $urandom_range(31);
      cycle();
    end
    drain(12);
    for (int k = 0; k < NI; k++) chk("queue_empty", k, 64'(exq[k].size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
